// File: rtl/bmem_line_arbiter.sv
// N-channel line-granular arbiter in front of the single burst memory port.
// Serialises one whole-line read or write at a time and returns the line to its owner.
module bmem_line_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int BURST     = 4,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              req_valid,
  input  logic [NUM_CH-1:0]              req_write,
  input  logic [NUM_CH*ADDR_W-1:0]       req_addr,
  input  logic [NUM_CH*BURST*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH-1:0]              req_cancel,
  output logic [NUM_CH-1:0]              req_ready,
  output logic [NUM_CH-1:0]              resp_valid,
  output logic [BURST*DATA_W-1:0]        resp_rdata,
  output logic [ADDR_W-1:0]              bmem_addr,
  output logic                           bmem_read,
  output logic                           bmem_write,
  output logic [DATA_W-1:0]              bmem_wdata,
  input  logic                           bmem_ready,
  input  logic [ADDR_W-1:0]              bmem_raddr,
  input  logic [DATA_W-1:0]              bmem_rdata,
  input  logic                           bmem_rvalid
);
  // state    | meaning
  // IDLE     | no transaction; arbitrate among req_valid
  // GRANT    | winner latched, line address presented
  // WR_BEATS | stream write beats, advance on bmem_ready
  // RD_CMD   | hold bmem_read until accepted
  // RD_BEATS | collect beats whose raddr matches the latched line
  // RESP     | resp_valid pulse (unless dropped), then back to IDLE
  localparam int LINE_W = BURST * DATA_W;
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_WR_BEATS, S_RD_CMD, S_RD_BEATS, S_RESP
  } state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q, owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                write_q, drop_q;
  logic [ADDR_W-1:0]   addr_q, bmem_addr_q;
  logic [LINE_W-1:0]   line_q;
  logic [NUM_CH-1:0]   req_ready_q, resp_valid_q;
  logic                bmem_read_q, bmem_write_q;

  logic [PTR_W-1:0]    win_d, ptr_d, sel;
  logic                found;
  int                  idx;

  // Round-robin starts the search at ptr_q; fixed priority always starts at 0.
  always_comb begin
    win_d = '0;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (PRIO_MODE != 0) ? k : int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = PTR_W'(idx);
      if (!found && req_valid[sel]) begin
        found = 1'b1;
        win_d = sel;
      end
    end
    ptr_d = (win_d == PTR_W'(NUM_CH - 1)) ? '0 : win_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      drop_q       <= 1'b0;
      addr_q       <= '0;
      bmem_addr_q  <= '0;
      line_q       <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      if (state_q != S_IDLE && !write_q && req_cancel[owner_q]) drop_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            owner_q     <= win_d;
            ptr_q       <= ptr_d;
            write_q     <= req_write[win_d];
            addr_q      <= req_addr[int'(win_d)*ADDR_W +: ADDR_W];
            line_q      <= req_write[win_d] ? req_wdata[int'(win_d)*LINE_W +: LINE_W] : '0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= CH_ONE << win_d;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          bmem_addr_q <= addr_q;
          state_q     <= write_q ? S_WR_BEATS : S_RD_CMD;
        end
        S_WR_BEATS: begin
          if (!bmem_write_q) begin
            bmem_write_q <= 1'b1;
          end else if (bmem_ready) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q        <= '0;
              bmem_write_q <= 1'b0;
              resp_valid_q <= CH_ONE << owner_q;
              state_q      <= S_RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RD_CMD: begin
          if (!bmem_read_q) begin
            bmem_read_q <= 1'b1;
          end else if (bmem_ready) begin
            bmem_read_q <= 1'b0;
            state_q     <= S_RD_BEATS;
          end
        end
        S_RD_BEATS: begin
          // Beats tagged for another line belong to someone else; skip them.
          if (bmem_rvalid && bmem_raddr == addr_q) begin
            line_q[int'(cnt_q)*DATA_W +: DATA_W] <= bmem_rdata;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_RESP;
              if (!(drop_q || req_cancel[owner_q])) resp_valid_q <= CH_ONE << owner_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RESP: begin
          bmem_addr_q <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = (resp_valid_q != '0 && !write_q) ? line_q : '0;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_write_q ? line_q[int'(cnt_q)*DATA_W +: DATA_W] : '0;

endmodule
